// File: rtl/psram_pkg.sv
// psram_pkg: shared FSM state encoding and request legality limits for the PSRAM arbiter.
package psram_pkg;
    typedef logic [1:0] psram_state_t;
    localparam psram_state_t ST_IDLE  = 2'd0;
    localparam psram_state_t ST_ISSUE = 2'd1;
    localparam psram_state_t ST_BUSY  = 2'd2;
    localparam psram_state_t ST_ERR   = 2'd3;
    localparam int MIN_WR_LEN = 2;
endpackage

// File: rtl/psram_rr_arb2.sv
// psram_rr_arb2: two-way round-robin pick; the pointer moves away from every accepted winner.
module psram_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    input  logic       i_accept,
    output logic       o_win
);
    logic r_rr;
    assign o_win = &i_valid ? r_rr : i_valid[1];
    always_ff @(posedge i_clk) begin
        if (i_rst) r_rr <= 1'b0;
        else if (i_accept) r_rr <= ~o_win;
    end
endmodule

// File: rtl/psram_arb.sv
// psram_arb: grants one of two requesters, checks burst legality, hands the command to the
// PSRAM engine and returns a one-cycle done or error pulse to the owner.
module psram_arb
    import psram_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [1:0]              req_valid_i,
    output logic [1:0]              req_ready_o,
    input  logic [1:0]              req_we_i,
    input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2*LEN_WIDTH-1:0]  req_len_i,
    output logic [1:0]              rsp_done_o,
    output logic [1:0]              rsp_err_o,
    output logic                    core_valid_o,
    input  logic                    core_ready_i,
    output logic                    core_we_o,
    output logic [ADDR_WIDTH-1:0]   core_addr_o,
    output logic [LEN_WIDTH-1:0]    core_len_o,
    input  logic                    core_done_i,
    output logic                    owner_o,
    output logic                    busy_o
);
    localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(MIN_WR_LEN);

    psram_state_t          r_state;
    logic                  r_owner, r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [1:0]            r_done;
    logic                  w_live, w_accept, w_win, w_we, w_legal, w_active;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [LEN_WIDTH-1:0]  w_len;
    logic [1:0]            w_hot;

    // Outputs are forced quiet while reset is held, even before the state register clears.
    assign w_live   = !rst_i;
    assign w_accept = w_live && r_state == ST_IDLE && en_i && |req_valid_i;

    psram_rr_arb2 u_rr (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_valid  (req_valid_i),
        .i_accept (w_accept),
        .o_win    (w_win)
    );

    assign w_we    = req_we_i[w_win];
    assign w_addr  = w_win ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
    assign w_len   = w_win ? req_len_i[2*LEN_WIDTH-1:LEN_WIDTH] : req_len_i[LEN_WIDTH-1:0];
    assign w_legal = !w_addr[0] && w_len != '0 && !(w_we && w_len < MIN_LEN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_done  <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_state <= w_legal ? ST_ISSUE : ST_ERR;
                    r_owner <= w_win;
                    r_we    <= w_we;
                    r_addr  <= w_addr;
                    r_len   <= w_len;
                end
                ST_ISSUE: if (core_ready_i) r_state <= ST_BUSY;
                ST_BUSY: if (core_done_i) begin
                    r_state <= ST_IDLE;
                    r_done  <= w_hot;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_hot        = r_owner ? 2'b10 : 2'b01;
    assign w_active     = w_live && (r_state == ST_ISSUE || r_state == ST_BUSY);
    assign req_ready_o  = w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_done_o   = w_live ? r_done : 2'b00;
    assign rsp_err_o    = (w_live && r_state == ST_ERR) ? w_hot : 2'b00;
    assign core_valid_o = w_live && r_state == ST_ISSUE;
    assign core_we_o    = w_active && r_we;
    assign core_addr_o  = w_active ? r_addr : '0;
    assign core_len_o   = w_active ? r_len : '0;
    assign busy_o       = w_live && r_state != ST_IDLE;
    assign owner_o      = busy_o && r_owner;
endmodule
